// File: rtl/packer.sv
// packer: registered word extractor. Picks OUT_W/8 consecutive bytes out of
// an IN_W-bit line, starting at a byte address. The byte index wraps around
// the end of the line, so unaligned addresses give a byte-rotated word.
// The output is registered, giving one cycle of latency, and there is no
// combinational path from the inputs to b.

module packer #(
    parameter int IN_W   = 128,
    parameter int OUT_W  = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   a,
    output logic [OUT_W-1:0]  b,
    input  logic [ADDR_W-1:0] address
);

    localparam int NB_IN  = IN_W / 8;
    localparam int NB_OUT = OUT_W / 8;

    // Bad parameter combinations stop elaboration instead of producing a
    // silently wrong selector.
    generate
        if ((IN_W % 8) != 0 || (OUT_W % 8) != 0) begin : g_bad_byte
            $error("packer: IN_W and OUT_W must be multiples of 8");
        end
        if ((IN_W % OUT_W) != 0) begin : g_bad_ratio
            $error("packer: IN_W must be a multiple of OUT_W");
        end
        if ((1 << ADDR_W) != NB_IN) begin : g_bad_addr
            $error("packer: ADDR_W must equal log2(IN_W/8)");
        end
    endgenerate

    logic [OUT_W-1:0]  word;
    logic [ADDR_W-1:0] idx;

    // Per-byte selector. ADDR_W bits index exactly NB_IN bytes, so the
    // natural overflow of address + i is the modulo-NB_IN wrap-around.
    always_comb begin
        word = '0;
        idx  = '0;
        for (int i = 0; i < NB_OUT; i++) begin
            idx              = address + ADDR_W'(i);
            word[8*i +: 8]   = a[8*idx +: 8];
        end
    end

    // Output register: cleared by reset, otherwise loaded every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            b <= '0;
        end else begin
            b <= word;
        end
    end

endmodule

// File: tb/tb_packer.sv
// Testbench for packer: directed vectors with hand-computed results, then a
// random run checked against an independent double-line shift model.

module tb_packer;

    localparam logic [127:0] LINE_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    logic         clk;
    logic         rst;
    logic [127:0] a;
    logic [31:0]  b;
    logic [3:0]   address;

    int n_tests;
    int n_fail;

    packer #(.IN_W(128), .OUT_W(32), .ADDR_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .address (address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: shift a doubled line right by the byte offset; the low word
    // is the wrapped selection.
    function automatic logic [31:0] ref_word(input logic [127:0] line, input logic [3:0] ad);
        logic [255:0] dbl;
        dbl = {line, line} >> (8 * ad);
        return dbl[31:0];
    endfunction

    logic [127:0] ra;
    logic [3:0]   raddr;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset holds b at zero regardless of inputs
        rst     = 1'b1;
        a       = LINE_A;
        address = 4'h4;
        step();
        chk("reset_edge1", b, 32'h0);
        step();
        chk("reset_edge2", b, 32'h0);

        // Aligned sweep
        rst     = 1'b0;
        address = 4'h0;
        step();
        chk("aligned_0", b, 32'hCCDDEEFF);
        address = 4'h4;
        step();
        chk("aligned_4", b, 32'h8899AABB);
        address = 4'h8;
        step();
        chk("aligned_8", b, 32'h44556677);
        address = 4'hC;
        step();
        chk("aligned_c", b, 32'h00112233);

        // Unaligned and wrap-around
        address = 4'h1;
        step();
        chk("unaligned_1", b, 32'hBBCCDDEE);
        address = 4'hF;
        step();
        chk("wrap_f", b, 32'hDDEEFF00);
        address = 4'hE;
        step();
        chk("wrap_e", b, 32'hEEFF0011);
        address = 4'hD;
        step();
        chk("wrap_d", b, 32'hFF001122);

        // Reset mid-stream, then immediate resume
        address = 4'h0;
        step();
        chk("stream_0", b, 32'hCCDDEEFF);
        address = 4'h4;
        step();
        chk("stream_4", b, 32'h8899AABB);
        rst     = 1'b1;
        address = 4'h8;
        step();
        chk("midreset", b, 32'h0);
        rst     = 1'b0;
        address = 4'hC;
        step();
        chk("resume_c", b, 32'h00112233);

        // Different line to catch byte-order mistakes hidden by LINE_A
        a       = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        address = 4'h6;
        step();
        chk("pattern_6", b, 32'h09080706);
        address = 4'hB;
        step();
        chk("pattern_b", b, 32'h0E0D0C0B);

        // Random regression
        for (int i = 0; i < 1000; i++) begin
            ra      = {$urandom, $urandom, $urandom, $urandom};
            raddr   = 4'($urandom_range(0, 15));
            a       = ra;
            address = raddr;
            step();
            chk("random", b, ref_word(ra, raddr));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
